// File: rtl/arith_unit_seq.sv
// arith_unit_seq: multi-cycle add/subtract/transfer/decrement unit.
// The carry chain is walked CHUNK bits per clock so that wide operands do not
// need a full-width ripple path. Operands arrive on a valid/ready handshake and
// results leave on another one, with carry, signed overflow and zero flags.
module arith_unit_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // A width that is not a whole number of chunks cannot be walked chunk by chunk.
  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("arith_unit_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cry_q, cry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] y_sel;

  // Operand and effective-Y registers shift right by one chunk each BUSY cycle,
  // so the chunk being added always sits in the low CHUNK bits. The partial sum
  // enters the accumulator from the top and ends up aligned after N shifts.
  always_comb begin
    csum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]} + (CHUNK+1)'(cry_q);
    acc_next = (acc_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Effective Y operand chosen from sel at the moment operands are accepted.
  always_comb begin
    y_sel = b;
    unique case (sel)
      2'b00:   y_sel = b;
      2'b01:   y_sel = ~b;
      2'b10:   y_sel = '0;
      default: y_sel = '1;
    endcase
  end

  // Next-state and datapath control for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cry_d   = cry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          y_d     = y_sel;
          acc_d   = '0;
          cry_d   = cin;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = a_q >> CHUNK;
        y_d   = y_q >> CHUNK;
        acc_d = acc_next;
        cry_d = csum[CHUNK];
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(N - 1)) begin
          res_d   = acc_next;
          carry_d = csum[CHUNK];
          ovf_d   = (a_q[CHUNK-1] == y_q[CHUNK-1]) && (csum[CHUNK-1] != a_q[CHUNK-1]);
          zero_d  = (acc_next == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cry_q   <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cry_q   <= cry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = res_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_arith_unit_seq.sv
// Directed and randomised checks for arith_unit_seq at three parameter points.
module tb_arith_unit_seq;

  logic clk;
  logic rst_n;

  // Main instance: WIDTH=8, CHUNK=2.
  logic       inValid, inReady, outValid, outReady;
  logic [7:0] a, b, d;
  logic [1:0] sel;
  logic       cin, carry, overflow, zero;

  // Single-chunk instance: WIDTH=8, CHUNK=8.
  logic       s1InValid, s1InReady, s1OutValid, s1OutReady;
  logic [7:0] s1A, s1B, s1D;
  logic [1:0] s1Sel;
  logic       s1Cin, s1Carry, s1Ovf, s1Zero;

  // Wide instance: WIDTH=32, CHUNK=4.
  logic        s2InValid, s2InReady, s2OutValid, s2OutReady;
  logic [31:0] s2A, s2B, s2D;
  logic [1:0]  s2Sel;
  logic        s2Cin, s2Carry, s2Ovf, s2Zero;

  int vectors;
  int miscompares;

  arith_unit_seq #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .sel(sel), .cin(cin), .out_valid(outValid),
    .out_ready(outReady), .d(d), .carry(carry), .overflow(overflow), .zero(zero)
  );

  arith_unit_seq #(.WIDTH(8), .CHUNK(8)) dutS1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1InValid), .in_ready(s1InReady),
    .a(s1A), .b(s1B), .sel(s1Sel), .cin(s1Cin), .out_valid(s1OutValid),
    .out_ready(s1OutReady), .d(s1D), .carry(s1Carry), .overflow(s1Ovf), .zero(s1Zero)
  );

  arith_unit_seq #(.WIDTH(32), .CHUNK(4)) dutS2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s2InValid), .in_ready(s2InReady),
    .a(s2A), .b(s2B), .sel(s2Sel), .cin(s2Cin), .out_valid(s2OutValid),
    .out_ready(s2OutReady), .d(s2D), .carry(s2Carry), .overflow(s2Ovf), .zero(s2Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {zero, overflow, carry, d} of (A + Y + cin) at width w.
  function automatic logic [34:0] refModel(input int w, input logic [31:0] ta,
                                           input logic [31:0] tb, input logic [1:0] ts,
                                           input logic tc);
    logic [63:0] mask, y, full;
    logic [31:0] dd;
    logic        cc, vv, zz;
    mask = (64'd1 << w) - 64'd1;
    case (ts)
      2'b00:   y = {32'd0, tb};
      2'b01:   y = {32'd0, ~tb};
      2'b10:   y = 64'd0;
      default: y = {32'd0, 32'hFFFF_FFFF};
    endcase
    y    = y & mask;
    full = ({32'd0, ta} & mask) + y + {63'd0, tc};
    dd   = full[31:0] & mask[31:0];
    cc   = full[w];
    vv   = (ta[w-1] == y[w-1]) && (dd[w-1] != ta[w-1]);
    zz   = (dd == 32'd0);
    return {zz, vv, cc, dd};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic acceptOp(input logic [7:0] ta, input logic [7:0] tb,
                          input logic [1:0] ts, input logic tc);
    @(negedge clk);
    a = ta; b = tb; sel = ts; cin = tc; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    a = ~ta; b = ~tb; sel = ~ts; cin = ~tc;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (!outValid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                               input logic [1:0] ts, input logic tc, input logic [7:0] expD,
                               input logic expC, input logic expV, input logic expZ);
    int lat;
    acceptOp(ta, tb, ts, tc);
    waitDone(lat);
    checkOutput($sformatf("%s.latency", tag), 32'(lat), 32'd4);
    checkOutput($sformatf("%s.d", tag), 32'(d), 32'(expD));
    checkOutput($sformatf("%s.carry", tag), 32'(carry), 32'(expC));
    checkOutput($sformatf("%s.overflow", tag), 32'(overflow), 32'(expV));
    checkOutput($sformatf("%s.zero", tag), 32'(zero), 32'(expZ));
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput($sformatf("%s.drainValid", tag), 32'(outValid), 32'd0);
    checkOutput($sformatf("%s.drainReady", tag), 32'(inReady), 32'd1);
  endtask

  task automatic sweepS1();
    logic [34:0] e;
    int          lat;
    s1OutReady = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      s1A = 8'($urandom); s1B = 8'($urandom); s1Sel = 2'($urandom); s1Cin = 1'($urandom);
      e = refModel(8, 32'(s1A), 32'(s1B), s1Sel, s1Cin);
      s1InValid = 1'b1;
      @(posedge clk);
      #1;
      s1InValid = 1'b0;
      lat = 0;
      while (!s1OutValid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checkOutput("w8c8.latency", 32'(lat), 32'd1);
      checkOutput("w8c8.d", 32'(s1D), e[31:0]);
      checkOutput("w8c8.carry", 32'(s1Carry), 32'(e[32]));
      checkOutput("w8c8.overflow", 32'(s1Ovf), 32'(e[33]));
      checkOutput("w8c8.zero", 32'(s1Zero), 32'(e[34]));
      @(posedge clk);
      #1;
    end
    s1OutReady = 1'b0;
  endtask

  task automatic sweepS2();
    logic [34:0] e;
    int          lat;
    s2OutReady = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      s2A = $urandom; s2B = $urandom; s2Sel = 2'($urandom); s2Cin = 1'($urandom);
      if (i < 4) begin
        s2B = s2A;
        s2Sel = 2'b01;
        s2Cin = 1'b1;
      end
      e = refModel(32, s2A, s2B, s2Sel, s2Cin);
      s2InValid = 1'b1;
      @(posedge clk);
      #1;
      s2InValid = 1'b0;
      lat = 0;
      while (!s2OutValid && lat < 30) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checkOutput("w32c4.latency", 32'(lat), 32'd8);
      checkOutput("w32c4.d", s2D, e[31:0]);
      checkOutput("w32c4.carry", 32'(s2Carry), 32'(e[32]));
      checkOutput("w32c4.overflow", 32'(s2Ovf), 32'(e[33]));
      checkOutput("w32c4.zero", 32'(s2Zero), 32'(e[34]));
      @(posedge clk);
      #1;
    end
    s2OutReady = 1'b0;
  endtask

  // Directed sequence: reset, sel/cin table, flags, backpressure, mid-op reset,
  // back-to-back streaming, then the parameter sweeps.
  initial begin
    int          lat;
    int          cyc, issued, checked, lastAcc;
    logic [34:0] expQ[8];

    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    inValid = 0; outReady = 0; a = 0; b = 0; sel = 0; cin = 0;
    s1InValid = 0; s1OutReady = 0; s1A = 0; s1B = 0; s1Sel = 0; s1Cin = 0;
    s2InValid = 0; s2OutReady = 0; s2A = 0; s2B = 0; s2Sel = 0; s2Cin = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.inReady", 32'(inReady), 32'd1);
    checkOutput("rst.outValid", 32'(outValid), 32'd0);
    checkOutput("rst.d", 32'(d), 32'd0);
    checkOutput("rst.carry", 32'(carry), 32'd0);
    checkOutput("rst.overflow", 32'(overflow), 32'd0);
    checkOutput("rst.zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("sel00c0", 8'hAA, 8'h55, 2'b00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus("sel01c1", 8'hAA, 8'h55, 2'b01, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    applyStimulus("sel10c1", 8'hAA, 8'h55, 2'b10, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
    applyStimulus("sel11c0", 8'hAA, 8'h55, 2'b11, 1'b0, 8'hA9, 1'b1, 1'b0, 1'b0);
    applyStimulus("sel11c1", 8'hAA, 8'h55, 2'b11, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    applyStimulus("ovf", 8'h7F, 8'h01, 2'b00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    applyStimulus("zero", 8'h55, 8'h55, 2'b01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

    // Backpressure: result must hold while a competing operand set is offered.
    acceptOp(8'h12, 8'h34, 2'b00, 1'b0);
    waitDone(lat);
    checkOutput("bp.latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inValid = 1'b1; a = 8'hFF; b = 8'hFF; sel = 2'b00; cin = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp.d", 32'(d), 32'h46);
      checkOutput("bp.carry", 32'(carry), 32'd0);
      checkOutput("bp.outValid", 32'(outValid), 32'd1);
      checkOutput("bp.inReady", 32'(inReady), 32'd0);
    end
    @(negedge clk);
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("bp.release.inReady", 32'(inReady), 32'd1);
    checkOutput("bp.release.outValid", 32'(outValid), 32'd0);
    checkOutput("bp.release.d", 32'(d), 32'h46);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bp.noCapture", 32'(inReady), 32'd1);

    // Reset during the second BUSY cycle.
    acceptOp(8'hF0, 8'h0F, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRst.inReady", 32'(inReady), 32'd1);
    checkOutput("midRst.outValid", 32'(outValid), 32'd0);
    checkOutput("midRst.d", 32'(d), 32'd0);
    checkOutput("midRst.carry", 32'(carry), 32'd0);
    checkOutput("midRst.overflow", 32'(overflow), 32'd0);
    checkOutput("midRst.zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("postRst", 8'h03, 8'h04, 2'b00, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with in_valid and out_ready both held high.
    cyc = 0; issued = 0; checked = 0; lastAcc = 0;
    outReady = 1'b1;
    inValid = 1'b1;
    while (checked < 8 && cyc < 200) begin
      @(negedge clk);
      if (outValid) begin
        checkOutput("b2b.d", 32'(d), expQ[checked][31:0]);
        checkOutput("b2b.carry", 32'(carry), 32'(expQ[checked][32]));
        checkOutput("b2b.overflow", 32'(overflow), 32'(expQ[checked][33]));
        checkOutput("b2b.zero", 32'(zero), 32'(expQ[checked][34]));
        checked++;
      end
      if (inReady && issued < 8) begin
        a = 8'($urandom); b = 8'($urandom); sel = 2'($urandom); cin = 1'($urandom);
        expQ[issued] = refModel(8, 32'(a), 32'(b), sel, cin);
        if (issued > 0) checkOutput("b2b.interval", 32'(cyc - lastAcc), 32'd6);
        lastAcc = cyc;
        issued++;
      end
      cyc++;
    end
    inValid = 1'b0;
    checkOutput("b2b.completed", 32'(checked), 32'd8);
    @(posedge clk);
    #1;
    outReady = 1'b0;

    sweepS1();
    sweepS2();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arith_unit_seq.md
# arith_unit_seq

Parametrised, multi-cycle successor to the 4-bit combinational arithmetic circuit. It computes add, subtract, transfer and decrement on WIDTH-bit operands. The carry chain is processed CHUNK bits per clock, so wide datapaths close timing without a full-width ripple path. It sits between an operand-issuing controller and a result consumer, with valid/ready handshakes on both sides, and adds status flags the 4-bit unit lacks.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; N = WIDTH/CHUNK cycles per operation.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset; the one clock and this reset are fixed.
- in_valid  in  1  operand set valid.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  2  B-operand select; sel[1] corresponds to the old s1, sel[0] to the old s0.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- d  out  WIDTH  result.
- carry  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow, defined as carry into MSB XOR carry out of MSB.
- zero  out  1  d == 0.

## Operation
- Effective operand Y is selected by sel:
  - 00: Y = b, giving A+B+cin.
  - 01: Y = ~b, giving A+~B+cin; with cin=1 this is A-B.
  - 10: Y = 0, giving A+cin (transfer/increment).
  - 11: Y = all ones, giving A-1+cin (decrement/transfer).
- Result is (A + Y + cin) mod 2^WIDTH. carry is bit WIDTH of the full sum.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, sel, cin; clear the chunk index; load the running carry with cin; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle adds chunk[idx] of A and Y plus the running carry, writes that chunk of d, updates the running carry, and increments idx.
  - After the chunk with idx == N-1, go to DONE and register carry, overflow and zero.
- DONE:
  - out_valid=1; d and the flags are held stable.
  - On out_ready, go to IDLE.
- in_valid while not in IDLE is ignored; no operand is captured.
- Input a, b, sel and cin may change after acceptance without affecting the result.
- rst_n low at any time, including mid-operation, aborts immediately. State goes to IDLE and the partial result is discarded.
- CHUNK == WIDTH is legal: a single BUSY cycle.
- WIDTH % CHUNK != 0 is an elaboration-time error.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, d=0, carry=0, overflow=0, zero=0.
- Accept at edge k. BUSY occupies edges k+1..k+N. out_valid rises after edge k+N, giving N cycles of latency.
- out_valid stays high and d/flags stay constant until the edge with out_ready=1. out_valid falls after that edge and in_ready rises in the same cycle.
- If out_ready is already high when out_valid rises, the result is consumed on the first DONE edge.
- Minimum issue interval is N+2 cycles. No overlap between operations is allowed.
- d and the flags change only on the final BUSY edge or on reset. Intermediate chunk writes go to an internal register and are not visible on d.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=8, CHUNK=2 (N=4).
- Reset, then a=0xAA, b=0x55 with every sel/cin pair:
  - 00/0 -> d=0xFF, c=0.
  - 01/1 -> d=0x55, c=1.
  - 10/1 -> d=0xAB, c=0.
  - 11/0 -> d=0xA9, c=1.
  - 11/1 -> d=0xAA, c=1.
  - out_valid rises exactly 4 cycles after each accept.
- Flags:
  - a=0x7F, b=0x01, sel=00, cin=0 -> d=0x80, overflow=1, carry=0, zero=0.
  - a=0x55, b=0x55, sel=01, cin=1 -> d=0x00, zero=1, carry=1, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> d/flags stable, in_ready=0, and a new in_valid with different operands is not captured. Release -> IDLE next cycle.
- Reset mid-op: assert rst_n=0 at the second BUSY cycle -> all outputs at reset values immediately. After release, the next operation is correct and the old operands leave no residue.
- Back-to-back: in_valid and out_ready held high with 8 random vectors -> each accepted at intervals of N+2 cycles, and every result matches the reference model (a + Y + cin).
- Parameter sweep: CHUNK=8 (latency 1) and WIDTH=32, CHUNK=4 (latency 8) -> 1000 random vectors match the model for d, carry, overflow and zero.
